// File: rtl/lsu_data_mem_if.sv
// ---------------------------------------------------------------------------
// lsu_data_mem_if
// Bus between the core's decode/ALU stage and the load/store responder.
//   rd_en  : load request          wr_en : store request (wins over rd_en)
//   func3  : RV32I size/sign code   addr  : byte address
//   wdata  : store data (rs2)       rdata : registered load result
//   stall  : core must hold PC/instr while high
//   err    : one-cycle pulse in DONE for an illegal or trapped access
// master modport = core side, slave modport = lsu_data_mem.
// ---------------------------------------------------------------------------
interface lsu_data_mem_if;
  logic        rd_en;
  logic        wr_en;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  modport master (
    output rd_en, wr_en, func3, addr, wdata,
    input  rdata, stall, err
  );

  modport slave (
    input  rd_en, wr_en, func3, addr, wdata,
    output rdata, stall, err
  );
endinterface

// File: rtl/lsu_data_mem.sv
// ---------------------------------------------------------------------------
// lsu_data_mem
// Load/store responder for the single-cycle RV32I datapath. Performs byte,
// halfword and word accesses on an internal word-organised memory after a
// programmable number of wait states, stalling the core until done.
//
// Parameters:
//   DEPTH   : memory size in 32-bit words (power of two)
//   LATENCY : wait-state (BUSY) cycles per access, 0..15
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : lsu_data_mem_if.slave (rd_en/wr_en/func3/addr/wdata in,
//             rdata/stall/err out)
// Optional feature macro:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//   suppressed and flagged on err; otherwise the address is aligned down.
// ---------------------------------------------------------------------------
module lsu_data_mem #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  lsu_data_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_s;
  logic        enter_done_s;

  // Fields of the access being committed this edge
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [2:0]  acc_func3_s;
  logic        acc_wr_s;
  logic [1:0]  off_s;
  logic [AW-1:0] idx_s;
  logic        bad_s;
  logic        misalign_s;
  logic [31:0] rword_s;
  logic [31:0] shifted_s;
  logic [31:0] load_val_s;
  logic [3:0]  wmask_s;
  logic [31:0] wword_s;
  logic        unused_addr_bits_s;

  logic [31:0] mem_q [DEPTH];

  // Store func3 must be SB/SH/SW; loads reject 011/110/111
  function automatic logic illegal_f(input logic wr, input logic [2:0] f3);
    if (wr) begin
      return !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010));
    end else begin
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
  endfunction

  assign req_s = bus.rd_en | bus.wr_en;

  // FSM state register, wait counter and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      func3_q <= 3'd0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next-state logic; enter_done_s marks the edge that commits the access
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func3_d      = func3_q;
    is_wr_d      = is_wr_q;
    enter_done_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          func3_d = bus.func3;
          is_wr_d = bus.wr_en;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d      = DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // <= guards against a stuck counter at zero
        if (cnt_q <= 4'd1) begin
          state_d      = DONE;
          enter_done_s = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        // Inputs here still belong to the completed instruction
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero latency the commit happens straight from IDLE using live inputs
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr_s  = bus.addr;
      acc_wdata_s = bus.wdata;
      acc_func3_s = bus.func3;
      acc_wr_s    = bus.wr_en;
    end else begin
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_func3_s = func3_q;
      acc_wr_s    = is_wr_q;
    end
  end

  assign idx_s              = acc_addr_s[AW+1:2];
  assign unused_addr_bits_s = ^acc_addr_s[31:AW+2];
  assign rword_s            = mem_q[idx_s];

  // Byte offset (aligned down by access size) and optional misalignment trap
  always_comb begin
    case (acc_func3_s[1:0])
      2'b00:   off_s = acc_addr_s[1:0];
      2'b01:   off_s = {acc_addr_s[1], 1'b0};
      default: off_s = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = ((acc_func3_s[1:0] == 2'b01) && acc_addr_s[0]) ||
                 ((acc_func3_s[1:0] == 2'b10) && (acc_addr_s[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
    bad_s = illegal_f(acc_wr_s, acc_func3_s) | misalign_s;
  end

  // Load extraction with sign/zero extension
  always_comb begin
    shifted_s = rword_s >> {off_s, 3'b000};
    case (acc_func3_s)
      3'b000:  load_val_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b001:  load_val_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b100:  load_val_s = {24'd0, shifted_s[7:0]};
      3'b101:  load_val_s = {16'd0, shifted_s[15:0]};
      default: load_val_s = rword_s;
    endcase
  end

  // Store byte enables and lane-aligned write data (little-endian)
  always_comb begin
    case (acc_func3_s[1:0])
      2'b00:   wmask_s = 4'b0001 << off_s;
      2'b01:   wmask_s = 4'b0011 << off_s;
      default: wmask_s = 4'b1111;
    endcase
    wword_s = acc_wdata_s << {off_s, 3'b000};
  end

  // Memory array is deliberately not reset; a reset edge drops the commit
  always_ff @(posedge clk) begin
    if (enter_done_s && acc_wr_s && !bad_s && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_s[b]) begin
          mem_q[idx_s][b*8 +: 8] <= wword_s[b*8 +: 8];
        end
      end
    end
  end

  // Registered load result and one-cycle error pulse valid in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= enter_done_s & bad_s;
      if (enter_done_s && !acc_wr_s && !bad_s) begin
        rdata_q <= load_val_s;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.stall = ((state_q == IDLE) & req_s) | (state_q == BUSY);

endmodule

// File: tb/tb_lsu_data_mem.sv
`timescale 1ns/1ps
module tb_lsu_data_mem;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lsu_data_mem_if bus ();

  lsu_data_mem #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          st_cnt;
  logic [31:0] rd_v;
  logic        err_v;
  bit          tmo;

  // Drive one request, count stall cycles, sample rdata/err in DONE.
  // Inputs stay asserted through DONE (they must be ignored there).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rv,
                        output logic ev, output bit to);
    int guard;
    @(negedge clk);
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.func3 = f3;
    bus.addr  = a;
    bus.wdata = wd;
    #1;
    stalls = bus.stall ? 1 : 0;
    to     = 1'b0;
    guard  = 0;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      stalls++;
      guard++;
      if (guard > 40) begin
        to = 1'b1;
        break;
      end
    end
    rv = bus.rdata;
    ev = bus.err;
  endtask

  task automatic idle();
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.func3 = 3'd0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rdata", bus.rdata, 32'h0000_0000);
    chk("reset_stall", bus.stall, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("nomem_stall", bus.stall, 1'b0);

    // Word store/load, stall length LATENCY+1 = 3
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'h8000_00FF, st_cnt, rd_v, err_v, tmo);
    chk("sw_timeout", tmo, 1'b0);
    chk("sw_stall_cycles", st_cnt, 3);
    chk("sw_rdata_unchanged", rd_v, 32'h0000_0000);
    chk("sw_err", err_v, 1'b0);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lw_stall_cycles", st_cnt, 3);
    chk("lw_rdata", rd_v, 32'h8000_00FF);
    chk("lw_err", err_v, 1'b0);

    // Byte access into a known word
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, st_cnt, rd_v, err_v, tmo);
    access(1'b0, 1'b1, 3'b000, 32'h23, 32'h1234_56AB, st_cnt, rd_v, err_v, tmo);
    chk("sb_err", err_v, 1'b0);
    access(1'b1, 1'b0, 3'b000, 32'h23, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lb_sext", rd_v, 32'hFFFF_FFAB);
    access(1'b1, 1'b0, 3'b100, 32'h23, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lbu_zext", rd_v, 32'h0000_00AB);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lw_after_sb", rd_v, 32'hAB22_3344);

    // Halfword access into upper half
    access(1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, st_cnt, rd_v, err_v, tmo);
    access(1'b0, 1'b1, 3'b001, 32'h32, 32'h5555_8001, st_cnt, rd_v, err_v, tmo);
    access(1'b1, 1'b0, 3'b001, 32'h32, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lh_sext", rd_v, 32'hFFFF_8001);
    access(1'b1, 1'b0, 3'b101, 32'h32, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lhu_zext", rd_v, 32'h0000_8001);
    access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lw_after_sh", rd_v, 32'h8001_F00D);

    // Address wrap: 0x1000 aliases word 0
    access(1'b0, 1'b1, 3'b010, 32'h1000, 32'h5A5A_1234, st_cnt, rd_v, err_v, tmo);
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("wrap_lw", rd_v, 32'h5A5A_1234);

    // rd_en and wr_en together: store wins, rdata untouched
    access(1'b1, 1'b1, 3'b010, 32'h0, 32'h0BAD_F00D, st_cnt, rd_v, err_v, tmo);
    chk("prio_rdata_held", rd_v, 32'h5A5A_1234);
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("prio_store_done", rd_v, 32'h0BAD_F00D);

    // Misaligned accesses are aligned down when the trap is not built in
    access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, st_cnt, rd_v, err_v, tmo);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw22_err", err_v, 1'b1);
    chk("lw22_rdata_held", rd_v, 32'h0BAD_F00D);
`else
    chk("lw22_err", err_v, 1'b0);
    chk("lw22_aligned", rd_v, 32'hAB22_3344);
    access(1'b1, 1'b0, 3'b001, 32'h33, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("lh33_aligned", rd_v, 32'hFFFF_8001);
`endif

    // Illegal load func3: err pulse for one cycle, rdata held
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st_cnt, rd_v, err_v, tmo);
    access(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("ill_ld_err", err_v, 1'b1);
    chk("ill_ld_stall_cycles", st_cnt, 3);
    chk("ill_ld_rdata_held", rd_v, 32'h8000_00FF);
    idle();
    @(negedge clk);
    chk("ill_ld_err_one_cycle", bus.err, 1'b0);

    // Illegal store func3: err, no memory write
    access(1'b0, 1'b1, 3'b100, 32'h10, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("ill_st_err", err_v, 1'b1);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("ill_st_no_write", rd_v, 32'h8000_00FF);
    chk("ill_st_err_cleared", err_v, 1'b0);

    // Reset during BUSY of a store: store discarded, outputs cleared at once
    access(1'b0, 1'b1, 3'b010, 32'h40, 32'h1122_3344, st_cnt, rd_v, err_v, tmo);
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("pre_reset_lw", rd_v, 32'h1122_3344);
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.func3 = 3'b010;
    bus.addr  = 32'h40;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("busy_stall", bus.stall, 1'b1);
    rst = 1'b1;
    idle();
    #1;
    chk("rst_stall_immediate", bus.stall, 1'b0);
    chk("rst_rdata_cleared", bus.rdata, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, st_cnt, rd_v, err_v, tmo);
    chk("rst_store_discarded", rd_v, 32'h1122_3344);
    chk("final_timeout", tmo, 1'b0);
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem.md
# lsu_data_mem

Load/store responder for the single-cycle RV32I datapath. It accepts the `rd_en`/`wr_en`/`func3` memory controls produced by instruction decode, plus the ALU address and rs2 store data. It performs byte, halfword or word accesses on an internal word-organised data memory with a programmable number of wait states. It returns sign- or zero-extended load data and holds the core with `stall` until the access completes.

## Interface
- `DEPTH`, 1024: data memory size in 32-bit words; power of two.
- `LATENCY`, 2: wait-state cycles per access, 0..15.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  load request from decode.
- `wr_en`  in  1  store request from decode.
- `func3`  in  3  access size/sign, RV32I encoding.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  load result; registered.
- `stall`  out  1  high while an access is in progress; core must hold its PC and instruction.
- `err`  out  1  one-cycle pulse in DONE for an illegal or misaligned access.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE:
  - `req = rd_en | wr_en`.
  - On `req`: latch `addr`, `wdata`, `func3`, `kind` (write if `wr_en`, since write has priority when both are high) and load the wait counter with `LATENCY`.
  - Go to BUSY, or to DONE if `LATENCY == 0`.
- BUSY: the counter decrements each cycle. When the counter reaches 1, go to DONE.
- Transition into DONE (edge): perform the access.
  - Store: byte-enable write, little-endian.
    - SB (000) writes byte `addr[1:0]` from `wdata[7:0]`.
    - SH (001) writes half `addr[1]` from `wdata[15:0]`.
    - SW (010) writes the full word.
  - Load: read the word and extract by `addr[1:0]` into `rdata`.
    - LB (000) and LH (001) sign-extend.
    - LW (010) returns the word.
    - LBU (100) and LHU (101) zero-extend.
- DONE: `stall=0`. Always return to IDLE next cycle; inputs in the DONE cycle are ignored, because they still belong to the completed instruction.
- Word index = `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- Illegal `func3`:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000/001/010.
  - Effect: no memory write, `rdata` unchanged, `err=1` in DONE.
- A store never changes `rdata`. `rdata` holds the last completed load.
- Memory contents are not reset.

## Timing
- Reset values: `rdata=0`, `stall=0`, `err=0`, state IDLE, counter 0. Reset mid-access returns to IDLE immediately; an uncommitted store is discarded.
- `stall` is combinational: `(state==IDLE & req) | state==BUSY`.
- A request occupies `LATENCY+2` cycles: IDLE request cycle, `LATENCY` BUSY cycles, then DONE. The core advances at the end of DONE.
- `rdata` and `err` are valid from the DONE cycle. `err` is high for exactly that cycle.
- Back-to-back requests: the IDLE cycle following DONE samples the next instruction. There is no bubble beyond the fixed `LATENCY+2`.
- Non-memory instructions (`req=0`) see `stall=0` with zero added latency.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned halfword (`addr[0]=1`) or word (`addr[1:0]!=0`) accesses are suppressed: no write, `rdata` unchanged, `err=1` in DONE.
  - Cycle count is unchanged.
- Undefined: alignment is not checked. Address bits below the access size are forced to zero (aligned down) and the access proceeds normally. `err` reports only illegal `func3`.

## Test plan
- Reset: assert `rst` during BUSY of an SW 0xDEADBEEF to 0x40, then LW 0x40 -> the old value is returned, `stall=0` immediately on reset, and `rdata=0` after reset.
- `LATENCY=2`: SW 0x8000_00FF to 0x10, then LW 0x10 -> `stall` high 3 cycles per access, `rdata=0x8000_00FF` in DONE of the load.
- Sub-word: SB 0xAB to 0x23, then LB 0x23 -> `0xFFFF_FFAB`; LBU 0x23 -> `0x0000_00AB`; LW 0x20 has byte 3 = 0xAB with the other bytes unchanged.
- Halfword: SH 0x8001 to 0x32, then LH 0x32 -> `0xFFFF_8001`; LHU 0x32 -> `0x0000_8001`.
- Wrap and priority, `DEPTH=1024`: SW to 0x1000 aliases word 0; `rd_en=wr_en=1` performs the store and leaves `rdata` unchanged.
- LW at 0x22:
  - Macro defined -> `err` pulses 1 cycle, no write.
  - Macro undefined -> reads word 0x20.
  - Illegal LOAD `func3=011` -> `err=1` in both builds.
